alu_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one ALU instance between NUM_REQ requesters.
- Accepts one operation at a time from the requester side and drives the ALU start/done protocol.
- Returns the 16-bit result to the winning requester, with a timeout guard against a missing done.
- Sits between test/traffic agents (or upstream masters) and the ALU. It is the ALU's only driver.

---
 rtl/def_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/def_pkg.sv
// Shared definitions for the ALU subsystem: the operation encoding, the
// arbiter state type, data widths and an opcode classification helper.
package def_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RES_W  = 16;

  // Operation encoding; codes 5 and 6 are undefined.
  typedef enum logic [OP_W-1:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4,
    rst_op = 3'd7
  } operation_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // True for the operations that actually need the ALU.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      add_op, and_op, xor_op, mul_op: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage : def_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req       - request vector
//   ptr       - highest-priority requester index for this scan
//   enable    - when low, nothing is granted
//   grant     - one-hot grant
//   index     - binary index of the granted requester
//   any_grant - a grant was issued
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any_grant
);

  logic [IDX_W-1:0] cand;

  // Scan from ptr upward with wrap-around; the first set bit wins.
  always_comb begin
    grant     = '0;
    index     = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (enable && !any_grant && req[cand]) begin
        grant[cand] = 1'b1;
        index       = cand;
        any_grant   = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, start/done
// sequencing with a timeout guard, and a one-cycle response to the winner.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   req_valid/A/B/op    - packed per-requester requests (slice i = requester i)
//   req_ready           - one-hot accept pulse (IDLE only)
//   rsp_valid/result/err- one-hot one-cycle response to the winner
//   alu_A/B/op/start    - ALU command, non-zero only in ISSUE
//   alu_done/result     - ALU completion, honoured only in ISSUE
//   busy                - state is not IDLE
module alu_arbiter
  import def_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_A,
  input  logic [NUM_REQ*DATA_W-1:0] req_B,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [RES_W-1:0]          rsp_result,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         alu_A,
  output logic [DATA_W-1:0]         alu_B,
  output logic [OP_W-1:0]           alu_op,
  output logic                      alu_start,
  input  logic                      alu_done,
  input  logic [RES_W-1:0]          alu_result,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  gidx;
  logic [IDX_W-1:0]  ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic              any_grant;
  logic              scan_en;
  logic [DATA_W-1:0] sel_a, sel_b, lat_a, lat_b;
  logic [OP_W-1:0]   sel_op, lat_op;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [RES_W-1:0]  res;
  logic              err;

  // Grants are only offered in IDLE and never while reset is asserted.
  assign scan_en = (state == IDLE) && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (scan_en),
    .grant     (grant),
    .index     (gidx),
    .any_grant (any_grant)
  );

  // Operand mux for the current winner.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gidx == IDX_W'(i)) begin
        sel_a  = req_A[i*DATA_W +: DATA_W];
        sel_b  = req_B[i*DATA_W +: DATA_W];
        sel_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  assign ptr_next = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
  assign cnt_next = cnt + CNT_W'(1);

  // Sequencer state, latched request and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_op <= '0;
      cnt    <= '0;
      res    <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_grant) begin
            win    <= gidx;
            lat_a  <= sel_a;
            lat_b  <= sel_b;
            lat_op <= sel_op;
            ptr    <= ptr_next;
            if (is_alu_op(sel_op)) begin
              state <= ISSUE;
            end else begin
              // no_op completes cleanly; rst_op and undefined codes flag an error.
              res   <= '0;
              err   <= (sel_op != no_op);
              state <= RESP;
            end
          end
        end
        ISSUE: begin
          if (alu_done) begin
            res   <= alu_result;
            err   <= 1'b0;
            cnt   <= '0;
            state <= RESP;
          end else if (cnt_next == CNT_W'(TIMEOUT)) begin
            res   <= '0;
            err   <= 1'b1;
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt_next;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = grant;
  assign busy      = (state != IDLE);

  // ALU command is only driven in ISSUE; start drops in the done cycle.
  assign alu_A     = (state == ISSUE) ? lat_a  : '0;
  assign alu_B     = (state == ISSUE) ? lat_b  : '0;
  assign alu_op    = (state == ISSUE) ? lat_op : '0;
  assign alu_start = (state == ISSUE) && !alu_done;

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) begin
      rsp_valid[win] = 1'b1;
    end
  end

  assign rsp_result = (state == RESP) ? res : '0;
  assign rsp_err    = (state == RESP) && err;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected grants
// and responses; a negedge monitor pops and compares them.
module tb_alu_arbiter;
  import def_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*8-1:0]   req_A;
  logic [N*8-1:0]   req_B;
  logic [N*3-1:0]   req_op;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     rsp_valid;
  logic [15:0]      rsp_result;
  logic             rsp_err;
  logic [7:0]       alu_A;
  logic [7:0]       alu_B;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic             alu_done;
  logic [15:0]      alu_result;
  logic             busy;

  logic             model_done;
  logic             spur_done;
  assign alu_done = model_done | spur_done;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy)
  );

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        err;
    bit          chk_lat;
  } rsp_exp_t;

  rsp_exp_t rsp_q[$];
  int       grant_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_done_cyc = -10;
  int start_cycles = 0;
  int grants_seen = 0;
  int rsps_seen = 0;
  int alu_lat = 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req_v, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ALU model: done L cycles after the first start cycle; L=0 never answers.
  initial begin
    logic [15:0] r;
    model_done = 1'b0;
    alu_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (alu_start === 1'b1 && reset === 1'b0) begin
        case (alu_op)
          3'd1:    r = 16'(alu_A) + 16'(alu_B);
          3'd2:    r = 16'(alu_A & alu_B);
          3'd3:    r = 16'(alu_A ^ alu_B);
          3'd4:    r = 16'(alu_A) * 16'(alu_B);
          default: r = 16'hDEAD;
        endcase
        if (alu_lat > 0) begin
          repeat (alu_lat) @(posedge clk);
          #1;
          model_done = 1'b1;
          alu_result = r;
          @(posedge clk);
          #1;
          model_done = 1'b0;
          alu_result = 16'hBAD0;
        end else begin
          while (alu_start === 1'b1) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
  end

  // Monitor: compares grants and responses against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    if (reset === 1'b0) begin
      if (alu_start) start_cycles++;
      if (req_ready != '0) begin
        grants_seen++;
        check("grant_subset_of_valid", 32'(req_ready & ~req_valid), 32'd0);
        if (grant_q.size() == 0) begin
          check("unexpected_grant", 32'(req_ready), 32'd0);
        end else begin
          int e;
          e = grant_q.pop_front();
          check("grant", 32'(req_ready), 32'(1 << e));
        end
      end
      if (rsp_valid != '0) begin
        rsps_seen++;
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          rsp_exp_t x;
          x = rsp_q.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(1 << x.idx));
          check("rsp_result", 32'(rsp_result), 32'(x.res));
          check("rsp_err", 32'(rsp_err), 32'(x.err));
          if (x.chk_lat) check("rsp_latency", 32'(cyc), 32'(last_done_cyc + 1));
        end
      end
      if (alu_done) last_done_cyc = cyc;
    end
  end

  task automatic wait_grants(input int target);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (grants_seen >= target) return;
    end
    check("grant_timeout", 32'(grants_seen), 32'(target));
  endtask

  task automatic wait_rsps(input int target);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (rsps_seen >= target) return;
    end
    check("rsp_timeout", 32'(rsps_seen), 32'(target));
  endtask

  task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_A[idx*8 +: 8]  = a;
    req_B[idx*8 +: 8]  = b;
    req_op[idx*3 +: 3] = op;
  endtask

  // One isolated request: expectations pushed, request held until granted.
  task automatic do_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input int lat, input logic [15:0] er,
                        input logic ee, input bit chk_lat, input int exp_starts);
    int s0, r0, g0;
    rsp_exp_t x;
    x.idx = idx; x.res = er; x.err = ee; x.chk_lat = chk_lat;
    alu_lat = lat;
    grant_q.push_back(idx);
    rsp_q.push_back(x);
    s0 = start_cycles;
    r0 = rsps_seen;
    g0 = grants_seen;
    @(posedge clk);
    #1;
    set_req(idx, a, b, op);
    req_valid[idx] = 1'b1;
    wait_grants(g0 + 1);
    #1;
    req_valid[idx] = 1'b0;
    wait_rsps(r0 + 1);
    #1;
    check("alu_start_cycles", 32'(start_cycles - s0), 32'(exp_starts));
    check("busy_after_rsp", 32'(busy), 32'd0);
  endtask

  initial begin
    int s0, r0, g0;
    rsp_exp_t x;
    reset      = 1'b1;
    req_valid  = '0;
    req_A      = '0;
    req_B      = '0;
    req_op     = '0;
    spur_done  = 1'b0;

    // Reset state, including no grant while reset holds a request off.
    #1;
    req_valid = 4'b0001;
    set_req(0, 8'h12, 8'h34, add_op);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_alu_start", 32'(alu_start), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_alu_A", 32'(alu_A), 32'd0);
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: single add, done one cycle after start.
    do_req(0, 8'h12, 8'h34, add_op, 1, 16'h0046, 1'b0, 1'b1, 1);
    // 2: mul with three-cycle latency.
    do_req(2, 8'hFF, 8'hFF, mul_op, 3, 16'hFE01, 1'b0, 1'b1, 3);
    // 5: timeout on a missing done, after 15 ISSUE cycles.
    do_req(3, 8'h5A, 8'h0F, and_op, 0, 16'h0000, 1'b1, 1'b0, TO);
    // Spurious done in IDLE must not produce a response.
    r0 = rsps_seen;
    @(posedge clk); #1; spur_done = 1'b1;
    @(posedge clk); #1; spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("spurious_done_rsp", 32'(rsps_seen), 32'(r0));
    check("spurious_done_busy", 32'(busy), 32'd0);

    // 3: round robin with all four held (pointer is back at 0 here).
    set_req(0, 8'hF0, 8'h0F, xor_op);
    set_req(1, 8'hAA, 8'h0F, xor_op);
    set_req(2, 8'h12, 8'h34, xor_op);
    set_req(3, 8'hFF, 8'h01, xor_op);
    alu_lat = 1;
    foreach (grant_q[i]) check("queue_clean", 32'd1, 32'd0);
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
    grant_q.push_back(3); grant_q.push_back(0);
    x.chk_lat = 1'b1; x.err = 1'b0;
    x.idx = 0; x.res = 16'h00FF; rsp_q.push_back(x);
    x.idx = 1; x.res = 16'h00A5; rsp_q.push_back(x);
    x.idx = 2; x.res = 16'h0026; rsp_q.push_back(x);
    x.idx = 3; x.res = 16'h00FE; rsp_q.push_back(x);
    x.idx = 0; x.res = 16'h00FF; rsp_q.push_back(x);
    g0 = grants_seen;
    r0 = rsps_seen;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    wait_grants(g0 + 5);
    #1;
    req_valid = '0;
    wait_rsps(r0 + 5);

    // 4: local operations never touch the ALU.
    do_req(1, 8'h77, 8'h88, no_op, 1, 16'h0000, 1'b0, 1'b0, 0);
    do_req(1, 8'h77, 8'h88, rst_op, 1, 16'h0000, 1'b1, 1'b0, 0);
    do_req(1, 8'h01, 8'h02, 3'd5, 1, 16'h0000, 1'b1, 1'b0, 0);

    // Done arriving in the timeout cycle wins.
    do_req(0, 8'h01, 8'h02, add_op, TO - 1, 16'h0003, 1'b0, 1'b1, TO - 1);

    // 6: reset during ISSUE of a mul; pointer would otherwise favour req3.
    alu_lat = 0;
    grant_q.push_back(2);
    g0 = grants_seen;
    r0 = rsps_seen;
    s0 = start_cycles;
    @(posedge clk);
    #1;
    set_req(2, 8'hFF, 8'hFF, mul_op);
    req_valid[2] = 1'b1;
    wait_grants(g0 + 1);
    #1;
    req_valid[2] = 1'b0;
    for (int i = 0; i < 20 && start_cycles == s0; i++) @(posedge clk);
    check("mid_op_started", 32'(start_cycles > s0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_alu_start", 32'(alu_start), 32'd0);
    check("midrst_alu_op", 32'(alu_op), 32'd0);
    check("midrst_alu_B", 32'(alu_B), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_rsp", 32'(rsps_seen), 32'(r0));

    alu_lat = 1;
    grant_q.push_back(2);
    grant_q.push_back(3);
    x.chk_lat = 1'b1; x.err = 1'b0;
    x.idx = 2; x.res = 16'h0030; rsp_q.push_back(x);
    x.idx = 3; x.res = 16'h00FF; rsp_q.push_back(x);
    g0 = grants_seen;
    set_req(2, 8'h10, 8'h20, add_op);
    set_req(3, 8'h0F, 8'hF0, xor_op);
    req_valid = 4'b1100;
    wait_grants(g0 + 1);
    #1;
    req_valid[2] = 1'b0;
    wait_grants(g0 + 2);
    #1;
    req_valid[3] = 1'b0;
    wait_rsps(r0 + 2);
    repeat (2) @(posedge clk);

    check("grant_q_drained", 32'(grant_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule : tb_alu_arbiter
